// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing control unit for the 9-bit-PC processor: fetches through R7,
// decodes the instruction register and drives every datapath enable and the FPU handshake.
module proc_ctrl_fsm #(
  parameter int FPU_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] din,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_c,
  input  logic        fpu_done,
  output logic        ir_in,
  output logic [7:0]  r_in,
  output logic        incr_pc,
  output logic [3:0]  sel,
  output logic        a_in,
  output logic        g_in,
  output logic        addsub,
  output logic        alu_and,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        fpu_start,
  output logic        done,
  output logic        fpu_err
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, FPU_WAIT} state_t;

  localparam logic [2:0] OP_MV     = 3'b000;
  localparam logic [2:0] OP_MVT_BR = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_LD     = 3'b100;
  localparam logic [2:0] OP_ST     = 3'b101;
  localparam logic [2:0] OP_AND    = 3'b110;
  localparam logic [2:0] OP_FPU    = 3'b111;

  localparam logic [3:0] SEL_PC  = 4'd7;
  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_IMM = 4'd9;
  localparam logic [3:0] SEL_DIN = 4'd10;
  localparam logic [3:0] SEL_HI  = 4'd11;
  localparam logic [3:0] SEL_FPU = 4'd12;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FPU_TIMEOUT - 1);

  state_t          state_reg;
  logic [15:0]     ir_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            fpu_err_reg;

  logic [2:0] opcode;
  logic       imm;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] rx_onehot;
  logic [3:0] sel_rx;
  logic [3:0] sel_ry;
  logic [3:0] sel_op2;

  logic is_mv;
  logic is_mvt;
  logic is_br;
  logic is_alu;
  logic is_ld;
  logic is_st;
  logic is_fpu;
  logic br_taken;
  logic fpu_timeout;
  logic unused_ir;

  assign opcode = ir_reg[15:13];
  assign imm    = ir_reg[12];
  assign rx     = ir_reg[11:9];
  assign ry     = ir_reg[2:0];

  // Immediate bits are consumed by the datapath through sel=9/11, not here.
  assign unused_ir = ^ir_reg[8:3];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rx_dec
      assign rx_onehot[gi] = (rx == 3'(gi));
    end
  endgenerate

  assign sel_rx  = {1'b0, rx};
  assign sel_ry  = {1'b0, ry};
  assign sel_op2 = imm ? SEL_IMM : sel_ry;

  assign is_mv  = (opcode == OP_MV);
  assign is_mvt = (opcode == OP_MVT_BR) && imm;
  assign is_br  = (opcode == OP_MVT_BR) && !imm;
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_fpu = (opcode == OP_FPU);

  function automatic logic cond_met(input logic [2:0] cond, input logic z,
                                    input logic n, input logic c);
    case (cond)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return !z;
      3'b011:  return !c;
      3'b100:  return c;
      3'b101:  return !n;
      3'b110:  return n;
      default: return 1'b0;
    endcase
  endfunction

  assign br_taken    = cond_met(rx, flag_z, flag_n, flag_c);
  assign fpu_timeout = (to_cnt_reg == TO_LAST);
  assign fpu_err     = fpu_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= T0;
      ir_reg      <= '0;
      to_cnt_reg  <= '0;
      fpu_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        T0: if (run) state_reg <= T1;
        T1: state_reg <= T2;
        T2: begin
          ir_reg    <= din;
          state_reg <= T3;
        end
        T3: begin
          if (is_mv || is_mvt || (is_br && !br_taken))
            state_reg <= T0;
          else
            state_reg <= T4;
        end
        T4: begin
          if (is_st) begin
            state_reg <= T0;
          end else if (is_fpu) begin
            to_cnt_reg <= '0;
            state_reg  <= FPU_WAIT;
          end else begin
            state_reg <= T5;
          end
        end
        T5: state_reg <= T0;
        FPU_WAIT: begin
          // A result arriving on the last allowed cycle still wins over the timeout.
          if (fpu_done) begin
            state_reg <= T0;
          end else if (fpu_timeout) begin
            fpu_err_reg <= 1'b1;
            state_reg   <= T0;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        default: state_reg <= T0;
      endcase
    end
  end

  always_comb begin
    ir_in     = 1'b0;
    r_in      = 8'h00;
    incr_pc   = 1'b0;
    sel       = 4'd0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    addsub    = 1'b0;
    alu_and   = 1'b0;
    addr_in   = 1'b0;
    dout_in   = 1'b0;
    w_d       = 1'b0;
    fpu_start = 1'b0;
    done      = 1'b0;
    // Enables are held off for the whole reset, even mid-instruction.
    if (rst) begin
      case (state_reg)
        T0: begin
          if (run) begin
            sel     = SEL_PC;
            addr_in = 1'b1;
            incr_pc = 1'b1;
          end
        end
        T2: ir_in = 1'b1;
        T3: begin
          if (is_mv) begin
            sel  = sel_op2;
            r_in = rx_onehot;
            done = 1'b1;
          end else if (is_mvt) begin
            sel  = SEL_HI;
            r_in = rx_onehot;
            done = 1'b1;
          end else if (is_br) begin
            if (br_taken) begin
              sel  = SEL_PC;
              a_in = 1'b1;
            end else begin
              done = 1'b1;
            end
          end else if (is_alu || is_fpu) begin
            sel  = sel_rx;
            a_in = 1'b1;
          end else begin
            sel     = sel_ry;
            addr_in = 1'b1;
          end
        end
        T4: begin
          if (is_br) begin
            sel  = SEL_IMM;
            g_in = 1'b1;
          end else if (is_alu) begin
            sel     = sel_op2;
            g_in    = 1'b1;
            addsub  = (opcode == OP_SUB);
            alu_and = (opcode == OP_AND);
          end else if (is_st) begin
            sel     = sel_rx;
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end else if (is_fpu) begin
            sel       = sel_ry;
            fpu_start = 1'b1;
          end
        end
        T5: begin
          if (is_br) begin
            sel  = SEL_G;
            r_in = 8'h80;
            done = 1'b1;
          end else if (is_ld) begin
            sel  = SEL_DIN;
            r_in = rx_onehot;
            done = 1'b1;
          end else begin
            sel  = SEL_G;
            r_in = rx_onehot;
            done = 1'b1;
          end
        end
        FPU_WAIT: begin
          if (fpu_done) begin
            sel  = SEL_FPU;
            r_in = rx_onehot;
            done = 1'b1;
          end else if (fpu_timeout) begin
            done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Instruction-sequencing control unit for the 9-bit-PC enhanced processor.
- Fetches 16-bit instructions using R7 as the program counter, decodes them and drives all datapath enables:
  - register loads, including R7in;
  - incr_pc, bus select, A/G loads, memory address/data/write strobes;
  - the FPU start/done handshake.
- Sits between instruction memory/datapath and the R7 counter; sole owner of incr_pc and R7in.

Parameters:
- FPU_TIMEOUT, 64: max cycles in FPU_WAIT before abort.
- TO_W, 7: width of the timeout counter; must hold FPU_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enables fetch of the next instruction.
- din  in  16  memory read data (instruction or load data).
- flag_z  in  1  zero flag of last G result.
- flag_n  in  1  negative flag.
- flag_c  in  1  carry flag.
- fpu_done  in  1  FPU result valid, one-cycle pulse.
- ir_in  out  1  load instruction register from din.
- r_in  out  8  one-hot register load; r_in[7] drives R7in.
- incr_pc  out  1  increment R7.
- sel  out  4  bus source: 0-7 = R0-R7, 8 = G, 9 = zero-extended IR[8:0], 10 = din, 11 = {IR[7:0],8'h00}, 12 = FPU result.
- a_in  out  1  load A.
- g_in  out  1  load G.
- addsub  out  1  ALU op: 0 = add, 1 = sub.
- alu_and  out  1  ALU op: AND, overrides addsub.
- addr_in  out  1  load memory address register from bus.
- dout_in  out  1  load memory write-data register from bus.
- w_d  out  1  memory write enable.
- fpu_start  out  1  one-cycle FPU start pulse.
- done  out  1  instruction complete, one cycle.
- fpu_err  out  1  sticky: FPU timeout occurred.

Behaviour:
- Instruction fields:
  - IR[15:13] = opcode; IR[12] = imm flag; IR[11:9] = rX; IR[2:0] = rY; IR[8:0] = immediate.
  - Opcodes: 000 mv, 001 mvt (IR[12]=1) or branch (IR[12]=0, condition in IR[11:9]), 010 add, 011 sub, 100 ld, 101 st, 110 and, 111 fpu.
- Branch conditions: 000 always, 001 eq (z), 010 ne (!z), 011 cc (!c), 100 cs (c), 101 pl (!n), 110 mi (n), 111 reserved = never taken.
- States: T0, T1, T2, T3, T4, T5, FPU_WAIT. Outputs are combinational from state and IR; every output not listed for a state is 0.
- T0:
  - run=1: sel=7, addr_in=1, incr_pc=1, go to T1.
  - run=0: all outputs 0, stay in T0.
- T1: memory latency; no outputs; go to T2.
- T2: ir_in=1; go to T3.
- T3:
  - mv: sel = imm ? 9 : rY; r_in[rX]=1; done; go to T0.
  - mvt: sel=11; r_in[rX]=1; done; go to T0.
  - branch, condition true: sel=7, a_in; go to T4.
  - branch, condition false: done; go to T0.
  - add/sub/and/fpu: sel=rX, a_in; go to T4.
  - ld/st: sel=rY, addr_in; go to T4.
- T4:
  - branch: sel=9, g_in, addsub=0; go to T5.
  - add/sub/and: sel = imm ? 9 : rY; g_in; addsub=1 for sub; alu_and=1 for and; go to T5.
  - ld: wait; go to T5.
  - st: sel=rX, dout_in, w_d, done; go to T0.
  - fpu: sel=rY, fpu_start=1; clear timeout counter; go to FPU_WAIT.
- T5:
  - branch: sel=8, r_in[7], done; go to T0.
  - alu: sel=8, r_in[rX], done; go to T0.
  - ld: sel=10, r_in[rX], done; go to T0.
- FPU_WAIT:
  - fpu_done is sampled only here, starting the cycle after fpu_start; a fpu_done in any other state is ignored.
  - fpu_done=1: sel=12, r_in[rX], done; go to T0.
  - Otherwise the counter increments. When it reaches FPU_TIMEOUT-1 without fpu_done: set fpu_err, assert done, no register write, go to T0.
- R7 rules:
  - incr_pc and r_in[7] are never asserted in the same cycle.
  - Any instruction with rX=7 that writes (mv, mvt, alu, ld, fpu) loads R7: a jump. The PC was already incremented in T0.
- run=0 mid-instruction: the instruction completes normally; the FSM then halts in T0.
- rst=0:
  - Asynchronously forces state T0, clears IR, counter and fpu_err.
  - All outputs are 0 while rst=0, including during an instruction in progress.
- fpu_err clears only on reset.

Test Plan:
- Reset then run=1, memory word 0 = mv R1,#5 (16'h1205):
  - T0 asserts incr_pc with sel=7.
  - T3 asserts sel=9, r_in=8'h02, done.
  - Next T0 fetches address 1; 4 cycles total.
- Branch always, offset 3 (16'h2003) at PC 4:
  - T3 a_in with sel=7; T4 g_in with sel=9, addsub=0; T5 r_in=8'h80 with sel=8.
  - incr_pc never coincides with r_in[7].
- beq (16'h2203) with flag_z=0: done in T3, no r_in. With flag_z=1: full 3-cycle execute path.
- sub R2,R3 (16'h6403): T3 sel=2 a_in; T4 sel=3 g_in addsub=1; T5 sel=8 r_in=8'h04.
- st R1,[R6] (16'hA206): T3 sel=6 addr_in; T4 sel=1 dout_in w_d done.
- FPU:
  - fpu R1,R2 with fpu_done after 5 cycles: one-cycle fpu_start; r_in=8'h02 with sel=12 in the done cycle.
  - Same instruction with no fpu_done: fpu_err=1 after 64 cycles, no register write.
  - Reset mid-FPU_WAIT: state returns to T0, fpu_err=0.
